// File: rtl/axis_pkt_source_pkg.sv
// -----------------------------------------------------------------------------
// axis_pkt_source_pkg
// Shared constants for the AXI-Stream packet source: FSM state encodings,
// payload mode selectors, default widths and the 8-bit LFSR step function.
// -----------------------------------------------------------------------------
package axis_pkt_source_pkg;

    // Default widths
    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned GAP_W_DEF  = 8;
    localparam int unsigned CNT_W_DEF  = 16;
    localparam int unsigned LEN_W      = 8;
    localparam int unsigned LFSR_W     = 8;
    localparam int unsigned STATE_W    = 2;

    // FSM state encodings
    localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
    localparam logic [STATE_W-1:0] ST_SEND = 2'd1;
    localparam logic [STATE_W-1:0] ST_GAP  = 2'd2;

    // Payload mode selectors
    localparam logic MODE_CNT  = 1'b0;
    localparam logic MODE_LFSR = 1'b1;

    // Fibonacci LFSR step for x^8 + x^6 + x^5 + x^4 + 1
    function automatic logic [LFSR_W-1:0] lfsr8_next(input logic [LFSR_W-1:0] d);
        return {d[6:0], d[7] ^ d[5] ^ d[4] ^ d[3]};
    endfunction

endpackage : axis_pkt_source_pkg

// File: rtl/axis_pkt_source_if.sv
// -----------------------------------------------------------------------------
// axis_pkt_source_if
// Downstream stream bus of the packet source.
//   m_data  : beat payload          (master -> slave)
//   m_valid : beat valid            (master -> slave)
//   m_last  : final beat of packet  (master -> slave)
//   m_ready : downstream ready      (slave  -> master)
// -----------------------------------------------------------------------------
interface axis_pkt_source_if
    import axis_pkt_source_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
);
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_last;
    logic              m_ready;

    modport master (
        output m_data,
        output m_valid,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_valid,
        input  m_last,
        output m_ready
    );
endinterface : axis_pkt_source_if

// File: rtl/axis_pkt_source_lfsr8.sv
// -----------------------------------------------------------------------------
// axis_lfsr8
// 8-bit Fibonacci LFSR (x^8 + x^6 + x^5 + x^4 + 1) with synchronous reload.
//   clk      : clock, rising edge
//   rst      : synchronous reset, active-high (state <- SEED)
//   i_load   : reload state with SEED (has priority over i_adv)
//   i_adv    : advance one step
//   o_next_c : combinational value the state takes on the next advance
// -----------------------------------------------------------------------------
module axis_lfsr8
    import axis_pkt_source_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 8'h01
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_adv,
    output logic [LFSR_W-1:0] o_next_c
);

    logic [LFSR_W-1:0] r_state;
    logic [LFSR_W-1:0] w_step;

    // Feedback network
    assign w_step   = lfsr8_next(r_state);
    assign o_next_c = w_step;

    // State register; reload wins so a new packet always starts from SEED
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SEED;
        end else if (i_load) begin
            r_state <= SEED;
        end else if (i_adv) begin
            r_state <= w_step;
        end
    end

endmodule : axis_lfsr8

// File: rtl/axis_pkt_source.sv
// -----------------------------------------------------------------------------
// axis_pkt_source
// 8-bit AXI-Stream style packet generator for bring-up and loopback traffic.
// A start pulse in IDLE launches one packet of pkt_len beats carrying either a
// beat counter or an LFSR sequence, followed by gap_len idle cycles.
//   clk       : clock, rising edge
//   rst       : synchronous reset, active-high
//   start     : packet request, sampled only in IDLE
//   pkt_len   : beats per packet (0 = request ignored)
//   gap_len   : idle cycles after the last beat
//   mode      : 0 = counting payload, 1 = LFSR payload
//   m_axis    : stream master (m_data/m_valid/m_last out, m_ready in)
//   busy      : high while sending or in the gap
//   pkt_done  : one-cycle pulse after the last beat handshakes
//   pkt_count : packets completed since reset (wraps)
// -----------------------------------------------------------------------------
module axis_pkt_source
    import axis_pkt_source_pkg::*;
#(
    parameter int unsigned       DATA_W    = DATA_W_DEF,
    parameter int unsigned       GAP_W     = GAP_W_DEF,
    parameter int unsigned       CNT_W     = CNT_W_DEF,
    parameter logic [LFSR_W-1:0] LFSR_SEED = 8'h01
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [LEN_W-1:0]     pkt_len,
    input  logic [GAP_W-1:0]     gap_len,
    input  logic                 mode,
    axis_pkt_source_if.master    m_axis,
    output logic                 busy,
    output logic                 pkt_done,
    output logic [CNT_W-1:0]     pkt_count
);

    // Registered state
    logic [STATE_W-1:0] r_state;
    logic [LEN_W-1:0]   r_len;
    logic [GAP_W-1:0]   r_gap;
    logic               r_mode;
    logic [LEN_W-1:0]   r_beat;
    logic [GAP_W-1:0]   r_gap_cnt;
    logic [DATA_W-1:0]  r_data;
    logic               r_valid;
    logic               r_last;
    logic               r_busy;
    logic               r_done;
    logic [CNT_W-1:0]   r_count;

    // Next-state values
    logic [STATE_W-1:0] w_state_nxt;
    logic [LEN_W-1:0]   w_len_nxt;
    logic [GAP_W-1:0]   w_gap_nxt;
    logic               w_mode_nxt;
    logic [LEN_W-1:0]   w_beat_nxt;
    logic [GAP_W-1:0]   w_gap_cnt_nxt;
    logic [DATA_W-1:0]  w_data_nxt;
    logic               w_valid_nxt;
    logic               w_last_nxt;
    logic               w_busy_nxt;
    logic               w_done_nxt;
    logic [CNT_W-1:0]   w_count_nxt;

    // Helpers
    logic               w_hs;
    logic [LEN_W-1:0]   w_beat_inc;
    logic [LEN_W-1:0]   w_len_m1;
    logic               w_lfsr_load;
    logic               w_lfsr_adv;
    logic [LFSR_W-1:0]  w_lfsr_next;

    assign w_hs       = r_valid & m_axis.m_ready;
    assign w_beat_inc = r_beat + LEN_W'(1);
    assign w_len_m1   = r_len - LEN_W'(1);

    // LFSR tracks the beat being presented; its look-ahead feeds the data register
    axis_lfsr8 #(
        .SEED     (LFSR_SEED)
    ) u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_lfsr_load),
        .i_adv    (w_lfsr_adv),
        .o_next_c (w_lfsr_next)
    );

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_len     <= '0;
            r_gap     <= '0;
            r_mode    <= MODE_CNT;
            r_beat    <= '0;
            r_gap_cnt <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_last    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_count   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_len     <= w_len_nxt;
            r_gap     <= w_gap_nxt;
            r_mode    <= w_mode_nxt;
            r_beat    <= w_beat_nxt;
            r_gap_cnt <= w_gap_cnt_nxt;
            r_data    <= w_data_nxt;
            r_valid   <= w_valid_nxt;
            r_last    <= w_last_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_count   <= w_count_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt   = r_state;
        w_len_nxt     = r_len;
        w_gap_nxt     = r_gap;
        w_mode_nxt    = r_mode;
        w_beat_nxt    = r_beat;
        w_gap_cnt_nxt = r_gap_cnt;
        w_data_nxt    = r_data;
        w_valid_nxt   = r_valid;
        w_last_nxt    = r_last;
        w_done_nxt    = 1'b0;
        w_count_nxt   = r_count;
        w_lfsr_load   = 1'b0;
        w_lfsr_adv    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // Latch the request so later input changes cannot disturb the packet
                if (start && (pkt_len != '0)) begin
                    w_state_nxt = ST_SEND;
                    w_len_nxt   = pkt_len;
                    w_gap_nxt   = gap_len;
                    w_mode_nxt  = mode;
                    w_beat_nxt  = '0;
                    w_valid_nxt = 1'b1;
                    w_last_nxt  = (pkt_len == LEN_W'(1));
                    w_data_nxt  = (mode == MODE_LFSR) ? DATA_W'(LFSR_SEED) : '0;
                    w_lfsr_load = 1'b1;
                end
            end

            ST_SEND: begin
                // Nothing moves while stalled, which keeps data/last stable
                if (w_hs) begin
                    if (r_last) begin
                        w_valid_nxt = 1'b0;
                        w_last_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_count_nxt = r_count + CNT_W'(1);
                        if (r_gap != '0) begin
                            w_state_nxt   = ST_GAP;
                            w_gap_cnt_nxt = r_gap - GAP_W'(1);
                        end else begin
                            w_state_nxt = ST_IDLE;
                        end
                    end else begin
                        w_beat_nxt = w_beat_inc;
                        w_last_nxt = (w_beat_inc == w_len_m1);
                        w_lfsr_adv = 1'b1;
                        w_data_nxt = (r_mode == MODE_LFSR) ? DATA_W'(w_lfsr_next)
                                                           : DATA_W'(w_beat_inc);
                    end
                end
            end

            ST_GAP: begin
                // Counter was preloaded with gap_len-1, so the gap lasts gap_len cycles
                if (r_gap_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt - GAP_W'(1);
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_valid_nxt = 1'b0;
                w_last_nxt  = 1'b0;
            end
        endcase

        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    // Output mapping
    assign m_axis.m_data  = r_data;
    assign m_axis.m_valid = r_valid;
    assign m_axis.m_last  = r_last;
    assign busy           = r_busy;
    assign pkt_done       = r_done;
    assign pkt_count      = r_count;

endmodule : axis_pkt_source

// File: tb/tb_axis_pkt_source.sv
// -----------------------------------------------------------------------------
// tb_axis_pkt_source
// Scoreboard bench for axis_pkt_source: stimulus pushes the expected beats of
// each requested packet, a negedge monitor pops and compares on handshake.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_axis_pkt_source;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  pkt_len = 8'd0;
    logic [7:0]  gap_len = 8'd0;
    logic        mode = 1'b0;
    logic        busy;
    logic        pkt_done;
    logic [15:0] pkt_count;

    axis_pkt_source_if #(.DATA_W(8)) m_if();

    axis_pkt_source #(
        .DATA_W    (8),
        .GAP_W     (8),
        .CNT_W     (16),
        .LFSR_SEED (8'h01)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .pkt_len   (pkt_len),
        .gap_len   (gap_len),
        .mode      (mode),
        .m_axis    (m_if),
        .busy      (busy),
        .pkt_done  (pkt_done),
        .pkt_count (pkt_count)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t exp_q[$];
    int   hs_stamps[$];
    int   hs_total = 0;
    int   cyc = 0;
    int   model_count = 0;
    bit   ready_auto = 1'b0;
    int   ready_pct = 100;
    bit   pat [0:6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Reference model: beat i is i (counting) or the i-th LFSR value from seed 01
    task automatic push_pkt(input int len, input bit md);
        logic [7:0] l;
        logic [7:0] d;
        l = 8'h01;
        for (int i = 0; i < len; i++) begin
            d = md ? l : 8'(i);
            exp_q.push_back('{data: d, last: (i == len - 1)});
            l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
        end
    endtask

    // Random ready generator
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (ready_auto) m_if.m_ready = ($urandom_range(0, 99) < ready_pct);
        end
    end

    // Monitor / scoreboard
    bit   prev_stall = 1'b0;
    bit   exp_done = 1'b0;
    exp_t e;
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            prev_stall = 1'b0;
            exp_done   = 1'b0;
        end else begin
            chk("pkt_done", pkt_done, exp_done);
            if (pkt_done) chk("pkt_count", pkt_count, 32'(model_count[15:0]));
            if (pkt_done && m_if.m_valid) fail("done_overlaps_valid");
            exp_done = 1'b0;
            if (prev_stall && !m_if.m_valid) fail("valid_dropped_without_handshake");
            if (m_if.m_valid) begin
                if (exp_q.size() == 0) begin
                    fail("unexpected_beat");
                end else begin
                    e = exp_q[0];
                    chk("beat_data", m_if.m_data, e.data);
                    chk("beat_last", m_if.m_last, e.last);
                    if (m_if.m_ready) begin
                        void'(exp_q.pop_front());
                        hs_stamps.push_back(cyc);
                        hs_total++;
                        if (e.last) begin
                            exp_done = 1'b1;
                            model_count++;
                        end
                    end
                end
            end
            prev_stall = m_if.m_valid && !m_if.m_ready;
        end
    end

    task automatic wait_idle();
        int k;
        k = 0;
        while (k < 3000) begin
            @(negedge clk);
            #2;
            if (exp_q.size() == 0 && !busy && !pkt_done) break;
            k++;
        end
        if (k >= 3000) fail("wait_idle_timeout");
        chk("idle_valid", m_if.m_valid, 0);
    endtask

    task automatic wait_hs(input int n);
        int k;
        k = 0;
        while (hs_total < n && k < 3000) begin
            @(posedge clk);
            k++;
        end
        if (hs_total < n) fail("wait_hs_timeout");
    endtask

    // Issue one start pulse; garbage the request inputs right after the latch
    task automatic send_pkt(input int len, input int gap, input bit md);
        wait_idle();
        @(posedge clk);
        #1;
        start   = 1'b1;
        pkt_len = 8'(len);
        gap_len = 8'(gap);
        mode    = md;
        if (len != 0) push_pkt(len, md);
        @(posedge clk);
        #1;
        start   = 1'b0;
        pkt_len = 8'($urandom_range(0, 255));
        gap_len = 8'($urandom_range(0, 255));
        mode    = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk("first_beat_latency", m_if.m_valid, (len != 0) ? 1 : 0);
    endtask

    int base;
    int cnt0;

    initial begin
        m_if.m_ready = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_data",  m_if.m_data, 0);
        chk("rst_valid", m_if.m_valid, 0);
        chk("rst_last",  m_if.m_last, 0);
        chk("rst_busy",  busy, 0);
        chk("rst_done",  pkt_done, 0);
        chk("rst_count", pkt_count, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // 1: counting packet at full rate
        hs_stamps.delete();
        send_pkt(4, 0, 1'b0);
        wait_idle();
        chk("t1_beats", hs_stamps.size(), 4);
        if (hs_stamps.size() == 4) chk("t1_consecutive", hs_stamps[3] - hs_stamps[0], 3);
        chk("t1_count", pkt_count, 1);

        // 2: two LFSR packets, each restarting at the seed
        send_pkt(5, 0, 1'b1);
        send_pkt(5, 0, 1'b1);
        wait_idle();
        chk("t2_count", pkt_count, 3);

        // 3: fixed backpressure pattern
        wait_idle();
        base = hs_total;
        @(posedge clk);
        #1;
        start = 1'b1; pkt_len = 8'd4; gap_len = 8'd0; mode = 1'b0;
        push_pkt(4, 1'b0);
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int p = 0; p < 7; p++) begin
            m_if.m_ready = pat[p];
            @(posedge clk);
            #1;
        end
        m_if.m_ready = 1'b1;
        chk("t3_handshakes", hs_total - base, 4);
        wait_idle();

        // 4: single beat with gap; start inside the gap is dropped
        send_pkt(1, 3, 1'b0);
        begin
            int k;
            k = 0;
            while (!pkt_done && k < 100) begin
                @(negedge clk);
                #2;
                k++;
            end
            if (!pkt_done) fail("t4_done_timeout");
        end
        chk("t4_busy_gap1", busy, 1);
        @(posedge clk);
        #1;
        start = 1'b1; pkt_len = 8'd5; gap_len = 8'd0; mode = 1'b0;
        @(negedge clk);
        chk("t4_busy_gap2", busy, 1);
        chk("t4_valid_gap2", m_if.m_valid, 0);
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("t4_busy_gap3", busy, 1);
        @(negedge clk);
        chk("t4_busy_idle", busy, 0);
        @(negedge clk);
        chk("t4_start_ignored", m_if.m_valid, 0);

        // 5: zero-length request, then reset in the middle of a packet
        send_pkt(0, 0, 1'b0);
        repeat (3) begin
            @(negedge clk);
            chk("t5_len0_valid", m_if.m_valid, 0);
            chk("t5_len0_busy", busy, 0);
        end
        base = hs_total;
        send_pkt(8, 0, 1'b0);
        wait_hs(base + 2);
        #1;
        rst = 1'b1;
        exp_q.delete();
        model_count = 0;
        @(negedge clk);
        @(negedge clk);
        chk("t5_rst_data",  m_if.m_data, 0);
        chk("t5_rst_valid", m_if.m_valid, 0);
        chk("t5_rst_last",  m_if.m_last, 0);
        chk("t5_rst_busy",  busy, 0);
        chk("t5_rst_done",  pkt_done, 0);
        chk("t5_rst_count", pkt_count, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // 6: start held high, three back-to-back packets
        wait_idle();
        hs_stamps.delete();
        base = hs_total;
        cnt0 = model_count;
        push_pkt(3, 1'b0);
        push_pkt(3, 1'b0);
        push_pkt(3, 1'b0);
        @(posedge clk);
        #1;
        start = 1'b1; pkt_len = 8'd3; gap_len = 8'd0; mode = 1'b0;
        wait_hs(base + 7);
        #1 start = 1'b0;
        wait_idle();
        chk("t6_beats", hs_stamps.size(), 9);
        if (hs_stamps.size() == 9) begin
            chk("t6_spacing_1_2", hs_stamps[3] - hs_stamps[2], 2);
            chk("t6_spacing_2_3", hs_stamps[6] - hs_stamps[5], 2);
        end
        chk("t6_count", pkt_count, 32'(cnt0 + 3));

        // Randomised traffic with random backpressure
        ready_pct  = 60;
        ready_auto = 1'b1;
        for (int n = 0; n < 25; n++) begin
            send_pkt($urandom_range(1, 24), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end
        wait_idle();
        ready_auto = 1'b0;
        #2 m_if.m_ready = 1'b1;
        chk("rand_count", pkt_count, 32'(model_count));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_axis_pkt_source
